gray_bmp_tx: RTL and testbench

- Egress-side counterpart to the BMP pixel loader in front of edge_detect_top.
- Drains the 8-bit grayscale result FIFO (first-word-fall-through: in_empty/in_dout/in_rd_en) and emits a byte-serial 24-bit BMP stream on a valid/ready interface, for a UART/DMA sink.
- Each gray sample is replicated to three bytes (B,G,R).
- Rows are zero-padded to a 4-byte multiple.
- With the optional feature compiled in, the 54-byte BMP header is emitted first.

---
 rtl/gray_bmp_tx.sv | 215 +++++++++++++++++++++
 tb/tb_gray_bmp_tx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_bmp_tx.sv
// gray_bmp_tx: drains an 8-bit grayscale FWFT FIFO and emits a byte-serial
// 24-bit BMP stream (each gray sample replicated to B,G,R, rows zero-padded
// to a 4-byte multiple) on a valid/ready interface.
// Optional macro GRAY_BMP_HEADER_EN: prepend the 54-byte BMP file header.
//
// state | meaning
// IDLE  | waiting for start
// HDR   | loading header bytes 0..53 (GRAY_BMP_HEADER_EN only)
// PIX   | loading pixel bytes, three replicas per FIFO pop
// PAD   | loading zero bytes to finish the row
// FIN   | waiting for the last byte to transfer, then pulse done
module gray_bmp_tx #(
    parameter int IMAGE_WIDTH  = 720,
    parameter int IMAGE_HEIGHT = 540,
    parameter int PPM          = 2835
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    input  logic       in_empty,
    input  logic [7:0] in_dout,
    output logic       in_rd_en,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready
);

    localparam logic [31:0] ROW_RAW  = 32'(3 * IMAGE_WIDTH);
    localparam logic [31:0] PAD      = (32'd4 - (ROW_RAW % 32'd4)) % 32'd4;
    localparam logic [1:0]  PAD_LAST = 2'(PAD - 32'd1);
    localparam logic [15:0] COL_LAST = 16'(IMAGE_WIDTH - 1);
    localparam logic [15:0] ROW_LAST = 16'(IMAGE_HEIGHT - 1);

`ifdef GRAY_BMP_HEADER_EN
    localparam logic [31:0] ROW_BYTES = ROW_RAW + PAD;
    localparam logic [31:0] IMG_SIZE  = ROW_BYTES * 32'(IMAGE_HEIGHT);
    localparam logic [31:0] FILE_SIZE = IMG_SIZE + 32'd54;
    // Byte 0 sits in the least significant lane, so every field is little-endian.
    localparam logic [431:0] HDR_BYTES = {
        32'd0, 32'd0, 32'(PPM), 32'(PPM), IMG_SIZE, 32'd0,
        16'd24, 16'd1, 32'(IMAGE_HEIGHT), 32'(IMAGE_WIDTH),
        32'd40, 32'd54, 32'd0, FILE_SIZE, 8'h4D, 8'h42
    };
`endif

    typedef enum logic [2:0] {
        S_IDLE,
`ifdef GRAY_BMP_HEADER_EN
        S_HDR,
`endif
        S_PIX,
        S_PAD,
        S_FIN
    } state_t;

    state_t      state, state_n;
    logic [15:0] col, col_n;
    logic [15:0] row, row_n;
    logic [1:0]  k, k_n;
    logic [1:0]  pad_cnt, pad_cnt_n;
    logic [7:0]  hold, hold_n;
    logic [7:0]  out_data_n;
    logic        out_valid_n;
    logic        busy_n;
    logic        done_n;
    logic        load_en;
`ifdef GRAY_BMP_HEADER_EN
    logic [5:0]  hdr_idx, hdr_idx_n;
    logic [7:0]  hdr_byte;
    assign hdr_byte = HDR_BYTES[{hdr_idx, 3'b000} +: 8];
`endif

    // The output register may take a new byte when empty or when its byte leaves.
    assign load_en  = !out_valid || out_ready;
    assign in_rd_en = load_en && (state == S_PIX) && (k == 2'd0) && !in_empty;

    // Next-state, counter and output-register logic.
    always_comb begin
        state_n     = state;
        col_n       = col;
        row_n       = row;
        k_n         = k;
        pad_cnt_n   = pad_cnt;
        hold_n      = hold;
        out_data_n  = out_data;
        out_valid_n = out_valid && !out_ready;
        busy_n      = busy;
        done_n      = 1'b0;
`ifdef GRAY_BMP_HEADER_EN
        hdr_idx_n   = hdr_idx;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    busy_n = 1'b1;
`ifdef GRAY_BMP_HEADER_EN
                    state_n = S_HDR;
`else
                    state_n = S_PIX;
`endif
                end
            end
`ifdef GRAY_BMP_HEADER_EN
            S_HDR: begin
                if (load_en) begin
                    out_data_n  = hdr_byte;
                    out_valid_n = 1'b1;
                    if (hdr_idx == 6'd53) begin
                        hdr_idx_n = 6'd0;
                        state_n   = S_PIX;
                    end else begin
                        hdr_idx_n = hdr_idx + 6'd1;
                    end
                end
            end
`endif
            S_PIX: begin
                if (load_en) begin
                    if (k == 2'd0) begin
                        // An empty FIFO simply leaves the register empty this cycle.
                        if (!in_empty) begin
                            out_data_n  = in_dout;
                            hold_n      = in_dout;
                            out_valid_n = 1'b1;
                            k_n         = 2'd1;
                        end
                    end else begin
                        out_data_n  = hold;
                        out_valid_n = 1'b1;
                        if (k == 2'd1) begin
                            k_n = 2'd2;
                        end else begin
                            k_n = 2'd0;
                            if (col == COL_LAST) begin
                                col_n = 16'd0;
                                if (PAD != 32'd0) begin
                                    state_n = S_PAD;
                                end else if (row == ROW_LAST) begin
                                    row_n   = 16'd0;
                                    state_n = S_FIN;
                                end else begin
                                    row_n = row + 16'd1;
                                end
                            end else begin
                                col_n = col + 16'd1;
                            end
                        end
                    end
                end
            end
            S_PAD: begin
                if (load_en) begin
                    out_data_n  = 8'h00;
                    out_valid_n = 1'b1;
                    if (pad_cnt == PAD_LAST) begin
                        pad_cnt_n = 2'd0;
                        if (row == ROW_LAST) begin
                            row_n   = 16'd0;
                            state_n = S_FIN;
                        end else begin
                            row_n   = row + 16'd1;
                            state_n = S_PIX;
                        end
                    end else begin
                        pad_cnt_n = pad_cnt + 2'd1;
                    end
                end
            end
            S_FIN: begin
                if (load_en) begin
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            col       <= 16'd0;
            row       <= 16'd0;
            k         <= 2'd0;
            pad_cnt   <= 2'd0;
            hold      <= 8'h00;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef GRAY_BMP_HEADER_EN
            hdr_idx   <= 6'd0;
`endif
        end else begin
            state     <= state_n;
            col       <= col_n;
            row       <= row_n;
            k         <= k_n;
            pad_cnt   <= pad_cnt_n;
            hold      <= hold_n;
            out_data  <= out_data_n;
            out_valid <= out_valid_n;
            busy      <= busy_n;
            done      <= done_n;
`ifdef GRAY_BMP_HEADER_EN
            hdr_idx   <= hdr_idx_n;
`endif
        end
    end

endmodule

// File: tb/tb_gray_bmp_tx.sv
// Scoreboard bench for gray_bmp_tx: a FIFO model feeds random gray pixels,
// a reference model builds the expected BMP byte stream into a queue, and a
// monitor pops and compares every byte the sink accepts.
module tb_gray_bmp_tx;
    localparam int W     = 3;
    localparam int H     = 2;
    localparam int PPM_V = 2835;
`ifdef GRAY_BMP_HEADER_EN
    localparam int HDR_LEN = 54;
`else
    localparam int HDR_LEN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       busy, done;
    logic       in_empty = 1'b1;
    logic [7:0] in_dout = 8'h00;
    logic       in_rd_en;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;

    gray_bmp_tx #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .PPM(PPM_V)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .in_empty(in_empty), .in_dout(in_dout), .in_rd_en(in_rd_en),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] fifo_q[$];
    int         frame_bytes;
    bit         bp_mode = 0, starve_mode = 0, stall_fifo = 0;
    int         pop_cnt = 0, xfer_cnt = 0, done_cnt = 0;
    int         neg_cnt = 0, last_xfer_neg = -10;
    bit         stall_prev = 0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] mon_e;
    bit         drv_pop;

    // FIFO and sink model: act on the previous edge's pop, then drive new inputs.
    always @(posedge clk) begin
        drv_pop = in_rd_en;
        #1;
        if (drv_pop && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            pop_cnt++;
        end
        out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        in_empty  = stall_fifo || (starve_mode && $urandom_range(0, 3) == 0) || (fifo_q.size() == 0);
        in_dout   = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    end

    // Monitor: every accepted byte is popped from the scoreboard and compared.
    always @(negedge clk) begin
        neg_cnt++;
        if (!rst) begin
            if (stall_prev) begin
                checks++;
                if (!out_valid || out_data !== prev_data) begin
                    failures++;
                    $display("FAIL stall_hold actual valid=%0b data=%02h required valid=1 data=%02h",
                             out_valid, out_data, prev_data);
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL extra_byte actual=%02h required=none", out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (out_data !== mon_e) begin
                        failures++;
                        $display("FAIL byte_%0d actual=%02h required=%02h", xfer_cnt, out_data, mon_e);
                    end
                end
                xfer_cnt++;
                last_xfer_neg = neg_cnt;
            end
            if (in_rd_en) begin
                checks++;
                if (in_empty) begin
                    failures++;
                    $display("FAIL rd_en_while_empty actual=1 required=0");
                end
            end
            if (done) begin
                checks++;
                if (neg_cnt != last_xfer_neg + 1 || exp_q.size() != 0 || busy) begin
                    failures++;
                    $display("FAIL done_timing actual gap=%0d left=%0d busy=%0b required gap=1 left=0 busy=0",
                             neg_cnt - last_xfer_neg, exp_q.size(), busy);
                end
                done_cnt++;
            end
        end else begin
            stall_prev = 0;
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push32(input logic [31:0] v);
        for (int i = 0; i < 4; i++) exp_q.push_back(v[8*i +: 8]);
    endtask

    // Reference model: a BMP file is header + rows of BGR triples padded to 4 bytes.
    task automatic build_frame(input bit fixed);
        int pad;
        int img;
        logic [7:0] v;
        pad = 0;
        while (((3 * W) + pad) % 4 != 0) pad++;
        img = (3 * W + pad) * H;
        frame_bytes = img + HDR_LEN;
`ifdef GRAY_BMP_HEADER_EN
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h4D);
        push32(32'(img + 54));
        push32(32'd0);
        push32(32'd54);
        push32(32'd40);
        push32(32'(W));
        push32(32'(H));
        exp_q.push_back(8'd1);  exp_q.push_back(8'd0);
        exp_q.push_back(8'd24); exp_q.push_back(8'd0);
        push32(32'd0);
        push32(32'(img));
        push32(32'(PPM_V));
        push32(32'(PPM_V));
        push32(32'd0);
        push32(32'd0);
`endif
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                v = fixed ? 8'(10 * (r * W + c + 1)) : 8'($urandom);
                fifo_q.push_back(v);
                repeat (3) exp_q.push_back(v);
            end
            repeat (pad) exp_q.push_back(8'h00);
        end
    endtask

    // mode: 0 plain, 1 backpressure, 2 backpressure+starve, 3 underflow,
    // 4 start while busy, 5 reset mid-frame
    task automatic run_frame(input int mode);
        int x0, p0, p1, d0, cyc;
        bit acted;
        x0 = xfer_cnt;
        p0 = pop_cnt;
        d0 = done_cnt;
        build_frame(mode == 0);
        bp_mode     = (mode == 1 || mode == 2 || mode == 4);
        starve_mode = (mode == 2);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        if (mode == 0) begin
            chk("first_valid_lat1", int'(out_valid), 0);
            tick();
            chk("first_valid_lat2", int'(out_valid), 1);
        end
        acted = 0;
        cyc = 0;
        while (done_cnt == d0 && cyc < 3000) begin
            tick();
            cyc++;
            if (!acted && mode == 3 && xfer_cnt - x0 >= HDR_LEN + 4) begin
                acted = 1;
                stall_fifo = 1;
                tick();
                tick();
                p1 = pop_cnt;
                repeat (18) tick();
                chk("underflow_valid_low", int'(out_valid), 0);
                chk("underflow_no_pop", pop_cnt - p1, 0);
                stall_fifo = 0;
            end
            if (!acted && mode == 4 && xfer_cnt - x0 >= HDR_LEN + 5) begin
                acted = 1;
                start = 1'b1;
                tick();
                start = 1'b0;
                chk("busy_ignores_start", int'(busy), 1);
            end
            if (mode == 5 && xfer_cnt - x0 >= 10) begin
                rst = 1'b1;
                #1;
                chk("rst_out_valid", int'(out_valid), 0);
                chk("rst_out_data", int'(out_data), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_done", int'(done), 0);
                chk("rst_rd_en", int'(in_rd_en), 0);
                exp_q.delete();
                fifo_q.delete();
                bp_mode = 0;
                tick();
                rst = 1'b0;
                tick();
                return;
            end
        end
        chk("frame_done_seen", int'(done_cnt != d0), 1);
        chk("frame_bytes", xfer_cnt - x0, frame_bytes);
        chk("frame_pops", pop_cnt - p0, W * H);
        bp_mode = 0;
        starve_mode = 0;
        repeat (5) tick();
        chk("single_done", done_cnt - d0, 1);
        chk("idle_after_done", int'(busy), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_data", int'(out_data), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_rd_en", int'(in_rd_en), 0);
        rst = 1'b0;
        tick();
        tick();
        run_frame(0);
        run_frame(1);
        run_frame(2);
        run_frame(2);
        run_frame(3);
        run_frame(4);
        run_frame(5);
        run_frame(0);
        run_frame(1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
